multicycle_control_unit: RTL and testbench

//  Multi-cycle control FSM for the reduced RISC-V core; next generation of the single-cycle decoder.

---
 rtl/multicycle_control_unit_pkg.sv | 79 +++++++
 rtl/multicycle_control_unit_if.sv | 40 ++++
 rtl/multicycle_control_unit_alu_decoder.sv | 41 ++++
 rtl/multicycle_control_unit.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit of the reduced RISC-V core.
// Holds the FSM state type, the ALU operation encoding, the ALU operation
// class handed to the ALU decoder, the base opcodes, the mux select encodings
// and a small helper that evaluates the supported branch conditions.
package multicycle_control_unit_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_t;

    // What kind of ALU operation the FSM wants this cycle; R and I classes
    // are resolved further from funct3/funct7 by the ALU decoder.
    typedef enum logic [1:0] {
        ALU_CLASS_ADD,
        ALU_CLASS_SUB,
        ALU_CLASS_R,
        ALU_CLASS_I
    } alu_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;
    localparam logic [1:0] IMM_J = 2'd3;

    localparam logic [1:0] RES_ALU_REG = 2'd0;
    localparam logic [1:0] RES_RDATA   = 2'd1;
    localparam logic [1:0] RES_ALU     = 2'd2;

    localparam logic [1:0] SRCA_PC     = 2'd0;
    localparam logic [1:0] SRCA_OLD_PC = 2'd1;
    localparam logic [1:0] SRCA_RS1    = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    // Returns {valid, taken}; valid is 0 for funct3 codes the core does not support.
    function automatic logic [1:0] branch_eval(input logic [2:0] funct3,
                                               input logic       eq,
                                               input logic       lt);
        case (funct3)
            3'b000:  branch_eval = {1'b1, eq};
            3'b001:  branch_eval = {1'b1, ~eq};
            3'b100:  branch_eval = {1'b1, lt};
            3'b101:  branch_eval = {1'b1, ~lt};
            default: branch_eval = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the control unit and the datapath / unified memory.
// master: the control unit (consumes IR, flags, mem_ready; drives strobes,
//         selects, alu_ctrl, illegal and the retired count).
// slave:  the datapath/memory side.
interface multicycle_control_unit_if #(
    parameter int ALU_CTRL_W = 3,
    parameter int CNT_W      = 32
);
    logic [31:0]           instr;
    logic                  eq;
    logic                  lt;
    logic                  mem_ready;
    logic                  mem_req;
    logic                  mem_we;
    logic                  adr_src;
    logic                  ir_write;
    logic                  pc_write;
    logic                  reg_write;
    logic [1:0]            alu_src_a;
    logic [1:0]            alu_src_b;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [1:0]            imm_src;
    logic [1:0]            result_src;
    logic                  illegal;
    logic [CNT_W-1:0]      retired;

    modport master (
        input  instr, eq, lt, mem_ready,
        output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src,
               illegal, retired
    );

    modport slave (
        output instr, eq, lt, mem_ready,
        input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src,
               illegal, retired
    );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU decoder: maps the FSM's ALU operation class plus funct3/funct7[5]
// to the ALU operation code.
// Ports: alu_class_i (op class), funct3_i, funct7b5_i -> alu_ctrl_o.
module alu_decoder
    import multicycle_control_unit_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  alu_class_t            alu_class_i,
    input  logic [2:0]            funct3_i,
    input  logic                  funct7b5_i,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_o
);

    alu_op_t op;

    // funct7[5] only selects SUB for register-register ops; immediate ops
    // always add for funct3 000. Unused funct3 codes fall back to ADD.
    always_comb begin
        op = ALU_ADD;
        case (alu_class_i)
            ALU_CLASS_SUB: op = ALU_SUB;
            ALU_CLASS_R, ALU_CLASS_I: begin
                case (funct3_i)
                    3'b000:  op = (alu_class_i == ALU_CLASS_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b111:  op = ALU_AND;
                    3'b110:  op = ALU_OR;
                    3'b100:  op = ALU_XOR;
                    3'b010:  op = ALU_SLT;
                    3'b001:  op = ALU_SLL;
                    3'b101:  op = ALU_SRL;
                    default: op = ALU_ADD;
                endcase
            end
            default: op = ALU_ADD;
        endcase
    end

    assign alu_ctrl_o = ALU_CTRL_W'(op);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the reduced RISC-V core.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB over one shared memory port with a
// req/ready handshake, counts retired instructions and traps on illegal
// opcodes, unsupported branch funct3 codes and memory timeouts.
// Ports: clk, rst (synchronous, active high), bus (master modport: IR and
// ALU flags in; memory handshake, datapath strobes/selects, illegal and
// retired out).
module multicycle_control_unit #(
    parameter int ALU_CTRL_W  = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_control_unit_if.master bus
);
    import multicycle_control_unit_pkg::*;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    if (ALU_CTRL_W < 3) begin : g_bad_alu_ctrl_w
        $error("ALU_CTRL_W must be at least 3");
    end
    if (MEM_TIMEOUT < 1) begin : g_bad_mem_timeout
        $error("MEM_TIMEOUT must be at least 1");
    end

    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [CNT_W-1:0]      retired_q;
    logic                  retire;
    logic                  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]            alu_src_a, alu_src_b, imm_src, result_src;
    alu_class_t            alu_class;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [1:0]            br;

    assign br = branch_eval(bus.instr[14:12], bus.eq, bus.lt);

    alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
        .alu_class_i (alu_class),
        .funct3_i    (bus.instr[14:12]),
        .funct7b5_i  (bus.instr[30]),
        .alu_ctrl_o  (alu_ctrl)
    );

    // Strobes and selects decode from the registered state; the FETCH write
    // strobes follow mem_ready and the BRANCH pc_write follows the condition.
    // The wait counter only runs while a request is outstanding, and hitting
    // the limit abandons the request in favour of TRAP.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        result_src = RES_ALU_REG;
        alu_class  = ALU_CLASS_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLD_PC;
                alu_src_b = SRCB_IMM;
                imm_src   = (bus.instr[6:0] == OP_BRANCH) ? IMM_B :
                            (bus.instr[6:0] == OP_JAL)    ? IMM_J : IMM_I;
                case (bus.instr[6:0])
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (bus.instr[6:0] == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (bus.instr[6:0] == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = RES_RDATA;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_class = ALU_CLASS_R;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_class = ALU_CLASS_I;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_class = ALU_CLASS_SUB;
                if (br[1]) begin
                    pc_write = br[0];
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_TRAP;
                end
            end
            S_JAL: begin
                // ALU forms oldPC + 4 for rd while the PC takes the target
                // held in the ALU result register since DECODE.
                alu_src_a = SRCA_OLD_PC;
                alu_src_b = SRCB_FOUR;
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        wait_d = '0;
        if (mem_req && !bus.mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
            if (wait_d == WAIT_W'(MEM_TIMEOUT)) state_d = S_TRAP;
        end
    end

    // State, wait counter and retired counter share one synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Everything is forced low while rst is high so a reset mid-access drops
    // the request and no write strobe can fire in a reset cycle.
    assign bus.mem_req    = mem_req   & ~rst;
    assign bus.mem_we     = mem_we    & ~rst;
    assign bus.adr_src    = adr_src   & ~rst;
    assign bus.ir_write   = ir_write  & ~rst;
    assign bus.pc_write   = pc_write  & ~rst;
    assign bus.reg_write  = reg_write & ~rst;
    assign bus.alu_src_a  = rst ? 2'd0 : alu_src_a;
    assign bus.alu_src_b  = rst ? 2'd0 : alu_src_b;
    assign bus.imm_src    = rst ? 2'd0 : imm_src;
    assign bus.result_src = rst ? 2'd0 : result_src;
    assign bus.alu_ctrl   = rst ? '0 : alu_ctrl;
    assign bus.illegal    = (state_q == S_TRAP);
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: directed scenarios with literal
// expectations followed by randomized instruction/handshake traffic, all
// checked every cycle against an instruction-level reference model.
module tb_multicycle_control_unit;

    localparam int ALU_CTRL_W  = 3;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    // Model phases of an instruction's life; numbering is arbitrary.
    localparam int PH_FETCH = 1, PH_DECODE = 2, PH_ADDR = 3, PH_LOAD = 4, PH_LOAD_WB = 5,
                   PH_STORE = 6, PH_EXEC_R = 7, PH_EXEC_I = 8, PH_WB = 9, PH_BRANCH = 10,
                   PH_JAL = 11, PH_TRAP = 12;

    typedef struct packed {
        logic       memReq;
        logic       memWe;
        logic       adrSrc;
        logic       irWrite;
        logic       pcWrite;
        logic       regWrite;
        logic [1:0] srcA;
        logic [1:0] srcB;
        logic [2:0] alu;
        logic [1:0] imm;
        logic [1:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   testsRun = 0;
    int   testsFailed = 0;
    int   phase = PH_FETCH;
    int   waitCnt = 0;
    logic [CNT_W-1:0] modelRetired = '0;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALU_CTRL_W(ALU_CTRL_W), .CNT_W(CNT_W)) bus ();

    multicycle_control_unit #(
        .ALU_CTRL_W  (ALU_CTRL_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ALU operation numbers straight from the instruction-set table.
    function automatic int aluTable(input bit isImm, input logic [2:0] f3, input logic f7b5);
        case (f3)
            3'b000:  return (!isImm && f7b5) ? 1 : 0;
            3'b111:  return 2;
            3'b110:  return 3;
            3'b100:  return 4;
            3'b010:  return 5;
            3'b001:  return 6;
            3'b101:  return 7;
            default: return 0;
        endcase
    endfunction

    // Branch outcome: 1 taken, 0 not taken, -1 unsupported funct3.
    function automatic int branchOutcome(input logic [2:0] f3, input logic e, input logic l);
        case (f3)
            3'b000:  return e ? 1 : 0;
            3'b001:  return e ? 0 : 1;
            3'b100:  return l ? 1 : 0;
            3'b101:  return l ? 0 : 1;
            default: return -1;
        endcase
    endfunction

    function automatic exp_t expected(input int ph, input logic r, input logic [31:0] ins,
                                      input logic e, input logic l, input logic rdy);
        exp_t x;
        logic [6:0] op;
        x  = '0;
        op = ins[6:0];
        if (r) return x;
        case (ph)
            PH_FETCH:   begin x.memReq = 1; x.srcB = 2; x.res = 2; x.irWrite = rdy; x.pcWrite = rdy; end
            PH_DECODE:  begin x.srcA = 1; x.srcB = 1;
                              x.imm = (op == 7'h63) ? 2'd2 : (op == 7'h6F) ? 2'd3 : 2'd0; end
            PH_ADDR:    begin x.srcA = 2; x.srcB = 1; x.imm = (op == 7'h23) ? 2'd1 : 2'd0; end
            PH_LOAD:    begin x.memReq = 1; x.adrSrc = 1; end
            PH_LOAD_WB: begin x.regWrite = 1; x.res = 1; end
            PH_STORE:   begin x.memReq = 1; x.memWe = 1; x.adrSrc = 1; end
            PH_EXEC_R:  begin x.srcA = 2; x.alu = 3'(aluTable(0, ins[14:12], ins[30])); end
            PH_EXEC_I:  begin x.srcA = 2; x.srcB = 1; x.alu = 3'(aluTable(1, ins[14:12], ins[30])); end
            PH_WB:      x.regWrite = 1;
            PH_BRANCH:  begin x.srcA = 2; x.alu = 3'd1;
                              x.pcWrite = (branchOutcome(ins[14:12], e, l) == 1); end
            PH_JAL:     begin x.srcA = 1; x.srcB = 2; x.regWrite = 1; x.pcWrite = 1; end
            default:    x = '0;
        endcase
        return x;
    endfunction

    task automatic checkOutput(input logic r, input logic [31:0] ins, input logic e,
                               input logic l, input logic rdy);
        exp_t x;
        x = expected(phase, r, ins, e, l, rdy);
        check("mem_req",    64'(bus.mem_req),    64'(x.memReq));
        check("mem_we",     64'(bus.mem_we),     64'(x.memWe));
        check("adr_src",    64'(bus.adr_src),    64'(x.adrSrc));
        check("ir_write",   64'(bus.ir_write),   64'(x.irWrite));
        check("pc_write",   64'(bus.pc_write),   64'(x.pcWrite));
        check("reg_write",  64'(bus.reg_write),  64'(x.regWrite));
        check("alu_src_a",  64'(bus.alu_src_a),  64'(x.srcA));
        check("alu_src_b",  64'(bus.alu_src_b),  64'(x.srcB));
        check("alu_ctrl",   64'(bus.alu_ctrl),   64'(x.alu));
        check("imm_src",    64'(bus.imm_src),    64'(x.imm));
        check("result_src", 64'(bus.result_src), 64'(x.res));
        check("illegal",    64'(bus.illegal),    64'(phase == PH_TRAP));
        check("retired",    64'(bus.retired),    64'(modelRetired));
    endtask

    task automatic advanceModel(input logic r, input logic [31:0] ins, input logic e,
                                input logic l, input logic rdy);
        int nxt;
        bit waiting;
        logic [6:0] op;
        op = ins[6:0];
        if (r) begin
            phase = PH_FETCH;
            waitCnt = 0;
            modelRetired = '0;
            return;
        end
        nxt = phase;
        waiting = (phase == PH_FETCH || phase == PH_LOAD || phase == PH_STORE) && !rdy;
        case (phase)
            PH_FETCH:   if (rdy) nxt = PH_DECODE;
            PH_DECODE:  nxt = (op == 7'h03 || op == 7'h23) ? PH_ADDR :
                              (op == 7'h33) ? PH_EXEC_R : (op == 7'h13) ? PH_EXEC_I :
                              (op == 7'h63) ? PH_BRANCH : (op == 7'h6F) ? PH_JAL : PH_TRAP;
            PH_ADDR:    nxt = (op == 7'h23) ? PH_STORE : PH_LOAD;
            PH_LOAD:    if (rdy) nxt = PH_LOAD_WB;
            PH_STORE:   if (rdy) begin nxt = PH_FETCH; modelRetired++; end
            PH_EXEC_R, PH_EXEC_I: nxt = PH_WB;
            PH_LOAD_WB, PH_WB, PH_JAL: begin nxt = PH_FETCH; modelRetired++; end
            PH_BRANCH:  if (branchOutcome(ins[14:12], e, l) < 0) nxt = PH_TRAP;
                        else begin nxt = PH_FETCH; modelRetired++; end
            default:    nxt = PH_TRAP;
        endcase
        if (waiting) begin
            waitCnt++;
            if (waitCnt == MEM_TIMEOUT) nxt = PH_TRAP;
        end else begin
            waitCnt = 0;
        end
        phase = nxt;
    endtask

    // One clock cycle: drive on the falling edge, compare 1 ns later, then
    // step the model so it matches the state after the next rising edge.
    task automatic applyStimulus(input logic r, input logic [31:0] ins, input logic e,
                                 input logic l, input logic rdy);
        @(negedge clk);
        rst           = r;
        bus.instr     = ins;
        bus.eq        = e;
        bus.lt        = l;
        bus.mem_ready = rdy;
        #1;
        checkOutput(r, ins, e, l, rdy);
        advanceModel(r, ins, e, l, rdy);
    endtask

    task automatic runCycle(input logic [31:0] ins, input logic rdy);
        applyStimulus(1'b0, ins, 1'b0, 1'b0, rdy);
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 99);
        if (k < 15)      v[6:0] = 7'h03;
        else if (k < 30) v[6:0] = 7'h23;
        else if (k < 48) v[6:0] = 7'h33;
        else if (k < 66) v[6:0] = 7'h13;
        else if (k < 84) begin
            v[6:0] = 7'h63;
            if ($urandom_range(0, 9) != 0) begin
                case ($urandom_range(0, 3))
                    0:       v[14:12] = 3'b000;
                    1:       v[14:12] = 3'b001;
                    2:       v[14:12] = 3'b100;
                    default: v[14:12] = 3'b101;
                endcase
            end
        end
        else if (k < 94) v[6:0] = 7'h6F;
        else             v[6:0] = 7'($urandom_range(0, 127));
        return v;
    endfunction

    initial begin
        logic [31:0] curInstr;
        int memReqCycles;
        int illegalCycles;
        int trapCycles;

        rst = 1'b1;
        bus.instr = '0;
        bus.eq = 1'b0;
        bus.lt = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset held two cycles, with a request pending on the inputs.
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        check("reset_mem_req", 64'(bus.mem_req), 64'd0);

        // addi x1,x0,5 with immediate ready: reg_write lands in cycle 4.
        runCycle(32'h00500093, 1'b1);
        check("post_reset_retired", 64'(bus.retired), 64'd0);
        check("post_reset_illegal", 64'(bus.illegal), 64'd0);
        check("fetch_ir_write", 64'(bus.ir_write), 64'd1);
        runCycle(32'h00500093, 1'b1);
        runCycle(32'h00500093, 1'b1);
        check("addi_cycle3_reg_write", 64'(bus.reg_write), 64'd0);
        runCycle(32'h00500093, 1'b1);
        check("addi_cycle4_reg_write", 64'(bus.reg_write), 64'd1);

        // bne not taken (eq=1) then taken (eq=0).
        applyStimulus(1'b0, 32'h00209463, 1'b0, 1'b0, 1'b1);
        check("addi_retired", 64'(bus.retired), 64'd1);
        applyStimulus(1'b0, 32'h00209463, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h00209463, 1'b1, 1'b0, 1'b1);
        check("bne_eq_pc_write", 64'(bus.pc_write), 64'd0);
        applyStimulus(1'b0, 32'h00209463, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h00209463, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h00209463, 1'b0, 1'b0, 1'b1);
        check("bne_ne_pc_write", 64'(bus.pc_write), 64'd1);

        // lw with ready delayed 3 cycles in the read phase.
        runCycle(32'h0000A183, 1'b1);
        check("bne_retired", 64'(bus.retired), 64'd3);
        runCycle(32'h0000A183, 1'b1);
        runCycle(32'h0000A183, 1'b1);
        memReqCycles = 0;
        for (int i = 0; i < 4; i++) begin
            runCycle(32'h0000A183, (i == 3) ? 1'b1 : 1'b0);
            if (bus.mem_req === 1'b1 && bus.adr_src === 1'b1) memReqCycles++;
        end
        check("lw_mem_req_cycles", 64'(memReqCycles), 64'd4);
        runCycle(32'h0000A183, 1'b1);
        check("lw_wb_reg_write", 64'(bus.reg_write), 64'd1);
        check("lw_wb_result_src", 64'(bus.result_src), 64'd1);

        // sub, or, slt in EXEC_R.
        runCycle(32'h402081B3, 1'b1);
        check("lw_retired", 64'(bus.retired), 64'd4);
        runCycle(32'h402081B3, 1'b1);
        runCycle(32'h402081B3, 1'b1);
        check("sub_alu_ctrl", 64'(bus.alu_ctrl), 64'd1);
        runCycle(32'h402081B3, 1'b1);
        runCycle(32'h0020E1B3, 1'b1);
        runCycle(32'h0020E1B3, 1'b1);
        runCycle(32'h0020E1B3, 1'b1);
        check("or_alu_ctrl", 64'(bus.alu_ctrl), 64'd3);
        runCycle(32'h0020E1B3, 1'b1);
        runCycle(32'h0020A1B3, 1'b1);
        runCycle(32'h0020A1B3, 1'b1);
        runCycle(32'h0020A1B3, 1'b1);
        check("slt_alu_ctrl", 64'(bus.alu_ctrl), 64'd5);
        runCycle(32'h0020A1B3, 1'b1);

        // Illegal opcode 0x7F: sticky flag, retired frozen, cleared by rst.
        runCycle(32'h0000007F, 1'b1);
        runCycle(32'h0000007F, 1'b1);
        illegalCycles = 0;
        for (int i = 0; i < 10; i++) begin
            runCycle(32'h0000007F, 1'b1);
            if (bus.illegal === 1'b1 && bus.mem_req === 1'b0) illegalCycles++;
        end
        check("trap_illegal_cycles", 64'(illegalCycles), 64'd10);
        check("trap_retired_frozen", 64'(bus.retired), 64'd7);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        runCycle(32'h0, 1'b0);
        check("rst_clears_illegal", 64'(bus.illegal), 64'd0);

        // Memory never answers: TRAP after MEM_TIMEOUT waiting cycles.
        memReqCycles = 1;
        for (int i = 1; i < 16; i++) begin
            runCycle(32'h0, 1'b0);
            if (bus.mem_req === 1'b1) memReqCycles++;
        end
        check("timeout_req_cycles", 64'(memReqCycles), 64'd16);
        runCycle(32'h0, 1'b0);
        check("timeout_illegal", 64'(bus.illegal), 64'd1);
        check("timeout_mem_req", 64'(bus.mem_req), 64'd0);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);

        // Random traffic against the model.
        curInstr = randInstr();
        trapCycles = 0;
        for (int c = 0; c < 4000; c++) begin
            logic r;
            r = 1'b0;
            if (phase == PH_TRAP) begin
                trapCycles++;
                if (trapCycles > 3) r = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                r = 1'b1;
            end
            if (r) trapCycles = 0;
            if (phase == PH_FETCH) curInstr = randInstr();
            applyStimulus(r, curInstr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 99) < 60));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
